compare_accumulator: RTL and testbench

- Downstream of the 2-bit slice comparator (outputs A<B, A=B, A>B).
- Consumes one slice result per accepted beat, most significant slice first, over NUM_SLICES beats.
- Produces the full-width magnitude compare result (lt/eq/gt) with a valid/ready handshake on both sides.
- Lets the team compare 2*NUM_SLICES-bit operands using a single 2-bit comparator, time-multiplexed.

---
 rtl/compare_accumulator_pkg.sv | 25 ++
 rtl/compare_accumulator_if.sv | 29 ++
 rtl/compare_accumulator.sv | 97 +++++++++
 tb/tb_compare_accumulator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/compare_accumulator_pkg.sv
// cmp_pkg: shared types for the serial magnitude compare accumulator.
//   cmp_res_t   - packed {lt, eq, gt} triple as produced by the 2-bit slice comparator
//   CMP_EQ      - "equal so far" encoding, the neutral value of the accumulation
//   is_onehot() - true when exactly one of lt/eq/gt is set (a legal slice result)
//   acc_state_t - accumulator control states
package cmp_pkg;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_EQ = 3'b010;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } acc_state_t;

  function automatic logic is_onehot(input cmp_res_t r);
    return (r == 3'b100) || (r == 3'b010) || (r == 3'b001);
  endfunction

endpackage

// File: rtl/compare_accumulator_if.sv
// compare_accumulator_if: slice-in / result-out handshake bundle.
//   s_valid/s_ready/s_lt/s_eq/s_gt      - one slice compare result per accepted beat
//   m_valid/m_ready/m_lt/m_eq/m_gt/m_err - full-width compare result
// Modports: slave = accumulator side, master = producer/consumer side.
interface compare_accumulator_if;

  logic s_valid;
  logic s_ready;
  logic s_lt;
  logic s_eq;
  logic s_gt;
  logic m_valid;
  logic m_ready;
  logic m_lt;
  logic m_eq;
  logic m_gt;
  logic m_err;

  modport slave (
    input  s_valid, s_lt, s_eq, s_gt, m_ready,
    output s_ready, m_valid, m_lt, m_eq, m_gt, m_err
  );

  modport master (
    output s_valid, s_lt, s_eq, s_gt, m_ready,
    input  s_ready, m_valid, m_lt, m_eq, m_gt, m_err
  );

endinterface

// File: rtl/compare_accumulator.sv
// compare_accumulator: folds NUM_SLICES 2-bit slice compare results (MSB slice
// first) into one full-width lt/eq/gt result, so a single 2-bit comparator can
// compare 2*NUM_SLICES-bit operands over several beats.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - compare_accumulator_if.slave (slice input handshake, result output handshake)
module compare_accumulator
  import cmp_pkg::*;
#(
  parameter int NUM_SLICES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  compare_accumulator_if.slave   bus
);

  if (NUM_SLICES < 2 || NUM_SLICES > 64) begin : g_bad_param
    $error("compare_accumulator: NUM_SLICES must be in 2..64");
  end

  localparam int              CNT_W = $clog2(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SLICES - 1);

  acc_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  cmp_res_t         dec_q, dec_d;
  logic             err_q, err_d;
  cmp_res_t         beat_res;

  assign beat_res = {bus.s_lt, bus.s_eq, bus.s_gt};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    dec_d     = dec_q;
    err_d     = err_q;
    unique case (state_q)
      ACCUM: begin
        if (bus.s_valid) begin
          // Illegal slices only flag the error; for magnitude they act as eq.
          // The first legal lt/gt (most significant differing slice) wins.
          if (!is_onehot(beat_res)) begin
            err_d = 1'b1;
          end else if (!decided_q && !beat_res.eq) begin
            dec_d     = beat_res;
            decided_d = 1'b1;
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = RESULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESULT: begin
        if (bus.m_ready) begin
          state_d   = ACCUM;
          dec_d     = CMP_EQ;
          decided_d = 1'b0;
          err_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dec_q     <= CMP_EQ;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      dec_q     <= dec_d;
      err_q     <= err_d;
    end
  end

  // Outputs depend on state only, so m_ready never reaches s_ready combinationally.
  // The decision register idles at eq, so m_* are gated to zero outside RESULT.
  always_comb begin
    bus.s_ready = (state_q == ACCUM);
    bus.m_valid = (state_q == RESULT);
    bus.m_lt    = (state_q == RESULT) && dec_q.lt;
    bus.m_eq    = (state_q == RESULT) && dec_q.eq;
    bus.m_gt    = (state_q == RESULT) && dec_q.gt;
    bus.m_err   = (state_q == RESULT) && err_q;
  end

endmodule

// File: tb/tb_compare_accumulator.sv
// tb_compare_accumulator: directed and randomized bench for compare_accumulator
// (NUM_SLICES = 4). Expected results come from whole-operand integer compares.
module tb_compare_accumulator;
  import cmp_pkg::*;

  localparam int NS = 4;
  localparam int W  = 2 * NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_accumulator_if bus();

  compare_accumulator #(.NUM_SLICES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {m_valid, m_lt, m_eq, m_gt, m_err}
  function automatic logic [4:0] outs();
    return {bus.m_valid, bus.m_lt, bus.m_eq, bus.m_gt, bus.m_err};
  endfunction

  // Slice results a 2-bit comparator would produce, MSB slice in the top bits.
  function automatic logic [3*NS-1:0] slices_of(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3*NS-1:0] r;
    logic [1:0] a2, b2;
    for (int i = 0; i < NS; i++) begin
      a2 = a[2*i +: 2];
      b2 = b[2*i +: 2];
      r[3*i +: 3] = (a2 < b2) ? 3'b100 : (a2 == b2) ? 3'b010 : 3'b001;
    end
    return r;
  endfunction

  // {lt, eq, gt, err} from whole-operand compare
  function automatic logic [3:0] expect_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic err);
    return {a < b, a == b, a > b, err};
  endfunction

  task automatic beat(input string tag, input logic [2:0] v);
    @(negedge clk);
    bus.s_valid = 1'b1;
    {bus.s_lt, bus.s_eq, bus.s_gt} = v;
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    chk({tag, "_m_idle"}, 32'(bus.m_valid), 32'd0);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      {bus.s_lt, bus.s_eq, bus.s_gt} = 3'($urandom);
      chk({tag, "_gap"}, 32'(outs()), 32'd0);
    end
  endtask

  // Feeds NS slices (optional gap after beat gpos), then checks the result,
  // holds it for 'stall' cycles with m_ready low, and checks the return to ACCUM.
  task automatic run_cmp(input string tag, input logic [3*NS-1:0] sl, input int gpos,
                         input int glen, input int stall, input logic [3:0] exp);
    for (int i = 0; i < NS; i++) begin
      beat(tag, sl[3*(NS-1-i) +: 3]);
      if (i == gpos) idle(tag, glen);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.m_ready = (stall == 0);
    chk({tag, "_result"}, 32'(outs()), 32'({1'b1, exp}));
    chk({tag, "_s_ready_res"}, 32'(bus.s_ready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      {bus.s_lt, bus.s_eq, bus.s_gt} = 3'($urandom);
      chk({tag, "_hold"}, 32'(outs()), 32'({1'b1, exp}));
      chk({tag, "_s_ready_hold"}, 32'(bus.s_ready), 32'd0);
      if (k == stall - 1) bus.m_ready = 1'b1;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk({tag, "_cleared"}, 32'(outs()), 32'd0);
    chk({tag, "_s_ready_back"}, 32'(bus.s_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0]    a, b, am, bm;
    logic [3*NS-1:0] sl;
    logic [2:0]      ill_tab [5];
    int              idx, gpos, glen, stall;
    logic            bad;

    ill_tab = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    bus.s_valid = 1'b0;
    {bus.s_lt, bus.s_eq, bus.s_gt} = 3'b000;
    bus.m_ready = 1'b1;

    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 0xB4 vs 0xB8: eq,eq,lt,eq
    run_cmp("lt_b4_b8", {3'b010, 3'b010, 3'b100, 3'b010}, -1, 0, 0, 4'b1000);
    // 0x5A vs 0x5A with a 3-cycle gap between beats 2 and 3
    run_cmp("eq_gap", {4{3'b010}}, 1, 3, 0, 4'b0100);
    // 0xC0 vs 0x3F: first gt sticks
    run_cmp("gt_sticky", {3'b001, 3'b100, 3'b100, 3'b100}, -1, 0, 0, 4'b0010);
    // illegal second slice, then a clean compare must not inherit err
    run_cmp("illegal", {3'b010, 3'b110, 3'b010, 3'b010}, -1, 0, 0, 4'b0101);
    run_cmp("err_clear", {4{3'b010}}, -1, 0, 0, 4'b0100);
    // 10-cycle stall with toggling inputs, then a compare proving nothing was consumed
    run_cmp("stall", slices_of(8'h37, 8'h29), -1, 0, 10, expect_of(8'h37, 8'h29, 1'b0));
    run_cmp("after_stall", slices_of(8'h12, 8'h13), -1, 0, 0, expect_of(8'h12, 8'h13, 1'b0));

    // reset after two lt beats
    beat("abort", 3'b100);
    beat("abort", 3'b100);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_rst_outs", 32'(outs()), 32'd0);
    chk("abort_rst_s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_cmp("fresh_gt", {3'b010, 3'b001, 3'b100, 3'b010}, -1, 0, 0, 4'b0010);

    // reset while a result is held
    for (int i = 0; i < NS; i++) beat("rst_res", 3'b100);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    chk("rst_res_pending", 32'(outs()), 32'b11000);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_res_outs", 32'(outs()), 32'd0);
    chk("rst_res_s_ready", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    run_cmp("post_rst", slices_of(8'hA0, 8'h0A), -1, 0, 0, expect_of(8'hA0, 8'h0A, 1'b0));

    // randomized compares; every fourth one carries one illegal slice
    for (int it = 0; it < 16; it++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 1) == 1) ? (a ^ (W'(1) << $urandom_range(0, W - 1))) : W'($urandom);
      if ($urandom_range(0, 4) == 0) b = a;
      sl  = slices_of(a, b);
      bad = ((it % 4) == 3);
      am  = a;
      bm  = b;
      if (bad) begin
        idx = $urandom_range(0, NS - 1);
        sl[3*idx +: 3] = ill_tab[$urandom_range(0, 4)];
        am[2*idx +: 2] = 2'b00;
        bm[2*idx +: 2] = 2'b00;
      end
      gpos  = $urandom_range(0, NS);
      if (gpos >= NS - 1) gpos = -1;
      glen  = $urandom_range(1, 3);
      stall = $urandom_range(0, 3);
      run_cmp($sformatf("rand%0d", it), sl, gpos, glen, stall, expect_of(am, bm, bad));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
